// File: rtl/uart_pkg.sv
// Shared types and baud constants for the UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_ODD,
    PAR_EVEN
  } parity_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } rx_state_e;

  localparam int CLKS_9600_50M   = 5208;
  localparam int CLKS_115200_50M = 434;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO; a push while full is accepted only
// when a pop frees a slot on the same edge.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_pop;
  logic             do_push;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM with false-start
// rejection, optional parity, 1/2 stop bits, and a receive FIFO with error flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int      CLKS_PER_BIT = CLKS_9600_50M,
  parameter int      DATA_BITS    = 8,
  parameter parity_e PARITY       = PAR_NONE,
  parameter int      STOP_BITS    = 1,
  parameter int      FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 nRst,
  input  logic                 rx_pin,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy,
  output rx_state_e            state_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = 4;
  localparam int EW = DATA_BITS + 2;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  logic                 sync_q;
  logic                 rx_s_q;
  rx_state_e            state_q;
  logic [CW-1:0]        cnt_q;
  logic [IW-1:0]        idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 perr_q;
  logic                 ferr_q;
  logic                 push_q;
  logic [EW-1:0]        push_data_q;
  logic                 overrun_q;
  logic                 bit_tick;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;
  logic [EW-1:0]        head;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      sync_q <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      sync_q <= rx_pin;
      rx_s_q <= sync_q;
    end
  end

  assign bit_tick = (cnt_q == BIT_LAST);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      push_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_q <= S_START;
            cnt_q   <= '0;
            idx_q   <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
          end
        end
        S_START: begin
          // A start bit that is high again at its midpoint was a glitch.
          if (cnt_q == HALF_LAST) begin
            cnt_q   <= '0;
            state_q <= rx_s_q ? S_IDLE : S_DATA;
          end else cnt_q <= cnt_q + 1'b1;
        end
        S_DATA: begin
          if (bit_tick) begin
            cnt_q   <= '0;
            shift_q <= {rx_s_q, shift_q[DATA_BITS-1:1]};
            if (idx_q == DATA_LAST) begin
              idx_q   <= '0;
              state_q <= (PARITY == PAR_NONE) ? S_STOP : S_PARITY;
            end else idx_q <= idx_q + 1'b1;
          end else cnt_q <= cnt_q + 1'b1;
        end
        S_PARITY: begin
          if (bit_tick) begin
            cnt_q   <= '0;
            perr_q  <= ((^shift_q) ^ rx_s_q) != (PARITY == PAR_ODD);
            state_q <= S_STOP;
          end else cnt_q <= cnt_q + 1'b1;
        end
        S_STOP: begin
          if (bit_tick) begin
            cnt_q <= '0;
            if (idx_q == STOP_LAST) begin
              push_q      <= 1'b1;
              push_data_q <= {shift_q, perr_q, ferr_q | ~rx_s_q};
              idx_q       <= '0;
              // Returning to IDLE mid-stop-bit lets a back-to-back start edge in.
              state_q     <= rx_s_q ? S_IDLE : S_WAIT_HIGH;
            end else begin
              ferr_q <= ferr_q | ~rx_s_q;
              idx_q  <= idx_q + 1'b1;
            end
          end else cnt_q <= cnt_q + 1'b1;
        end
        S_WAIT_HIGH: begin
          if (rx_s_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Handshake: an entry transfers on a clock edge where rx_valid && rx_ready;
  // the head entry is held stable while rx_valid && !rx_ready.
  assign pop = rx_valid && rx_ready;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) overrun_q <= 1'b0;
    else       overrun_q <= push_q && fifo_full && !pop;
  end

  uart_rx_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .nRst    (nRst),
    .push_i  (push_q),
    .wdata_i (push_data_q),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rx_valid   = !fifo_empty;
  assign rx_data    = head[EW-1:2];
  assign parity_err = head[1];
  assign frame_err  = head[0];
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);
  assign state_o    = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames driven on the pin, entries and flags
// checked against a queue built from frame-level rules.
`timescale 1ns/1ps
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CLKS  = 16;
  localparam int DW    = 8;
  localparam int W     = DW + 2;
  localparam int DEPTH = 4;
  localparam int LAT_8N1 = 2 + CLKS / 2 + (DW + 1) * CLKS + 2;
  localparam int LAT_8E2 = 2 + CLKS / 2 + (DW + 3) * CLKS + 2;

  // clock / reset
  logic clk = 1'b0;
  logic nRst;
  always #5 clk = ~clk;

  logic          pin_n, ready_n, valid_n, perr_n, ferr_n, ovr_n, busy_n;
  logic          pin_p, ready_p, valid_p, perr_p, ferr_p, ovr_p, busy_p;
  logic [DW-1:0] data_n, data_p;
  rx_state_e     st_n, st_p;

  uart_rx #(.CLKS_PER_BIT(CLKS), .DATA_BITS(DW), .PARITY(PAR_NONE),
            .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_none (
    .clk(clk), .nRst(nRst), .rx_pin(pin_n), .rx_data(data_n), .rx_valid(valid_n),
    .rx_ready(ready_n), .parity_err(perr_n), .frame_err(ferr_n), .overrun(ovr_n),
    .busy(busy_n), .state_o(st_n));

  uart_rx #(.CLKS_PER_BIT(CLKS), .DATA_BITS(DW), .PARITY(PAR_EVEN),
            .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_par (
    .clk(clk), .nRst(nRst), .rx_pin(pin_p), .rx_data(data_p), .rx_valid(valid_p),
    .rx_ready(ready_p), .parity_err(perr_p), .frame_err(ferr_p), .overrun(ovr_p),
    .busy(busy_p), .state_o(st_p));

  // scoreboard
  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_p_q[$];
  int tick = 0;
  int rise_tick = -1;
  int last_start = 0;
  int ovr_cnt = 0;
  int exp_ovr = 0;
  int pop_at = -1;
  int pop_rel = 0;
  bit prev_valid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // driver: hold the pin of one instance for n cycles while watching outputs
  task automatic hold_pin(input int inst, input logic val, input int n);
    logic v;
    if (inst == 0) pin_n = val; else pin_p = val;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tick++;
      v = (inst == 0) ? valid_n : valid_p;
      if (v && !prev_valid && rise_tick < 0) rise_tick = tick;
      prev_valid = v;
      if ((inst == 0) ? ovr_n : ovr_p) ovr_cnt++;
      ready_n = (tick == pop_at);
    end
  endtask

  task automatic send_frame(input int inst, input logic [DW-1:0] data,
                            input logic par_bit, input logic [1:0] stops);
    int nstop;
    logic perr, ferr;
    logic [W-1:0] e;
    nstop = (inst == 0) ? 1 : 2;
    perr = (inst == 1) && ((($countones(data) + int'(par_bit)) % 2) != 0);
    ferr = 1'b0;
    for (int i = 0; i < nstop; i++) if (!stops[i]) ferr = 1'b1;
    e = {data, perr, ferr};
    if (inst == 0) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(e); else exp_ovr++;
    end else begin
      if (exp_p_q.size() < DEPTH) exp_p_q.push_back(e); else exp_ovr++;
    end
    if (pop_rel > 0) pop_at = tick + pop_rel;
    pop_rel = 0;
    rise_tick = -1;
    prev_valid = (inst == 0) ? valid_n : valid_p;
    last_start = tick;
    hold_pin(inst, 1'b0, CLKS);
    for (int i = 0; i < DW; i++) hold_pin(inst, data[i], CLKS);
    if (inst == 1) hold_pin(inst, par_bit, CLKS);
    for (int i = 0; i < nstop; i++) hold_pin(inst, stops[i], CLKS);
  endtask

  task automatic check_head(input int inst, input string tag);
    int waited;
    logic v;
    logic [W-1:0] e;
    waited = 0;
    v = (inst == 0) ? valid_n : valid_p;
    while (!v && waited < 400) begin
      @(negedge clk); tick++; waited++;
      v = (inst == 0) ? valid_n : valid_p;
    end
    chk({tag, "_valid"}, 32'(v), 32'd1);
    e = '1;
    if (inst == 0 && exp_q.size() > 0) e = exp_q.pop_front();
    if (inst == 1 && exp_p_q.size() > 0) e = exp_p_q.pop_front();
    chk({tag, "_entry"}, (inst == 0) ? 32'({data_n, perr_n, ferr_n}) : 32'({data_p, perr_p, ferr_p}), 32'(e));
    if (inst == 0) ready_n = 1'b1; else ready_p = 1'b1;
    @(negedge clk); tick++;
    ready_n = 1'b0; ready_p = 1'b0;
  endtask

  initial begin
    nRst = 1'b0; pin_n = 1'b1; pin_p = 1'b1; ready_n = 1'b0; ready_p = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_none", 32'({data_n, valid_n, perr_n, ferr_n, ovr_n, busy_n}), 32'd0);
    chk("reset_par", 32'({data_p, valid_p, perr_p, ferr_p, ovr_p, busy_p}), 32'd0);
    chk("reset_state", 32'(st_n), 32'(S_IDLE));
    nRst = 1'b1;
    hold_pin(0, 1'b1, 5);

    // pop while empty is ignored
    ready_n = 1'b1; @(negedge clk); tick++; ready_n = 1'b0;
    chk("pop_empty", 32'(valid_n), 32'd0);

    // back-to-back 0x55, 0xA3
    send_frame(0, 8'h55, 1'b0, 2'b11);
    chk("lat_8n1", 32'(rise_tick - last_start), 32'(LAT_8N1));
    send_frame(0, 8'hA3, 1'b0, 2'b11);
    hold_pin(0, 1'b1, CLKS);
    check_head(0, "b2b_55");
    check_head(0, "b2b_a3");
    chk("b2b_idle", 32'({busy_n, valid_n}), 32'd0);

    // even parity, good then bad
    send_frame(1, 8'h07, 1'b1, 2'b11);
    chk("lat_8e2", 32'(rise_tick - last_start), 32'(LAT_8E2));
    hold_pin(1, 1'b1, CLKS);
    check_head(1, "par_good");
    send_frame(1, 8'h07, 1'b0, 2'b11);
    hold_pin(1, 1'b1, CLKS);
    check_head(1, "par_bad");

    // random frames, parity instance (some stop bits low)
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 3; j++) begin
        send_frame(1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                   {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)});
        hold_pin(1, 1'b1, 2 * CLKS);
      end
      for (int j = 0; j < 3; j++) check_head(1, "rand_par");
    end
    // random frames, no-parity instance
    for (int j = 0; j < 3; j++) begin
      send_frame(0, 8'($urandom_range(0, 255)), 1'b0, {1'b1, 1'($urandom_range(0, 3) != 0)});
      hold_pin(0, 1'b1, 2 * CLKS);
    end
    for (int j = 0; j < 3; j++) check_head(0, "rand_none");

    // false start
    hold_pin(0, 1'b0, 4);
    chk("glitch_busy", 32'(busy_n), 32'd1);
    hold_pin(0, 1'b1, 3 * CLKS);
    chk("glitch_idle", 32'({busy_n, valid_n}), 32'd0);
    chk("glitch_state", 32'(st_n), 32'(S_IDLE));

    // break: line low for three frame times
    exp_q.push_back({8'h00, 1'b0, 1'b1});
    hold_pin(0, 1'b0, 30 * CLKS);
    chk("break_state", 32'(st_n), 32'(S_WAIT_HIGH));
    check_head(0, "break");
    hold_pin(0, 1'b0, 2 * CLKS);
    chk("break_no_more", 32'({busy_n, valid_n}), 32'b10);
    hold_pin(0, 1'b1, 2 * CLKS);
    chk("break_release", 32'({busy_n, valid_n}), 32'd0);
    send_frame(0, 8'h5A, 1'b0, 2'b11);
    hold_pin(0, 1'b1, CLKS);
    check_head(0, "after_break");

    // overrun: five frames into a four-deep FIFO
    ovr_cnt = 0; exp_ovr = 0;
    for (int i = 1; i <= 5; i++) send_frame(0, 8'(i), 1'b0, 2'b11);
    hold_pin(0, 1'b1, 2 * CLKS);
    chk("ovr_count", 32'(ovr_cnt), 32'(exp_ovr));
    for (int i = 0; i < 4; i++) check_head(0, "ovr_drain");
    chk("ovr_empty", 32'(valid_n), 32'd0);

    // push and pop on the same edge while full
    ovr_cnt = 0; exp_ovr = 0;
    for (int i = 1; i <= 4; i++) send_frame(0, 8'(8'h10 + i), 1'b0, 2'b11);
    void'(exp_q.pop_front());
    pop_rel = LAT_8N1 - 1;
    send_frame(0, 8'h15, 1'b0, 2'b11);
    hold_pin(0, 1'b1, 2 * CLKS);
    chk("pushpop_ovr", 32'(ovr_cnt), 32'(exp_ovr));
    for (int i = 0; i < 4; i++) check_head(0, "pushpop_drain");
    chk("pushpop_empty", 32'(valid_n), 32'd0);

    // reset during bit 3 of 0xFF
    hold_pin(0, 1'b0, CLKS);
    hold_pin(0, 1'b1, 3 * CLKS + CLKS / 2);
    nRst = 1'b0;
    hold_pin(0, 1'b1, 3);
    chk("rst_mid_frame", 32'({busy_n, valid_n}), 32'd0);
    nRst = 1'b1;
    hold_pin(0, 1'b1, 2 * CLKS);
    chk("rst_no_push", 32'({busy_n, valid_n}), 32'd0);
    send_frame(0, 8'h3C, 1'b0, 2'b11);
    hold_pin(0, 1'b1, CLKS);
    check_head(0, "after_rst");
    chk("after_rst_empty", 32'(valid_n), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
